route_sequencer: RTL and testbench

Consumes the 4-entry slot map produced by the quadrant matching stage (output slot k takes source quadrant map[k]) and serialises it into one transfer command per cycle for the downstream quadrant mover. Validates that the map is a true permutation before emitting anything, applies valid/ready backpressure on both sides, and counts completed jobs.

---
 rtl/route_sequencer.sv | 131 +++++++++++++
 tb/tb_route_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/route_sequencer.sv
// rtl/route_sequencer.sv - serialises a validated 4-slot quadrant map into one transfer command per cycle
// Build macro SKIP_IDENTITY_EN: slots whose map entry equals their own index emit no command.
module route_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] map0,
  input  logic [1:0] map1,
  input  logic [1:0] map2,
  input  logic [1:0] map3,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_src,
  output logic [1:0] cmd_dst,
  output logic       cmd_last,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] job_count
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE, ERR} state_t;

  state_t          state;
  logic [3:0][1:0] map_q;
  logic [3:0]      mask;

  logic [3:0][1:0] map_in;
  logic            perm_ok;
  logic [3:0]      cap_mask;
  logic [1:0]      cap_k;
  logic [1:0]      emit_k;
  logic [3:0]      next_mask;
  logic [1:0]      next_k;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic single_bit(input logic [3:0] m);
    return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
  endfunction

  assign map_in  = {map3, map2, map1, map0};
  assign perm_ok = (map0 != map1) && (map0 != map2) && (map0 != map3) &&
                   (map1 != map2) && (map1 != map3) && (map2 != map3);

`ifdef SKIP_IDENTITY_EN
  assign cap_mask = {map3 != 2'd3, map2 != 2'd2, map1 != 2'd1, map0 != 2'd0};
`else
  assign cap_mask = 4'b1111;
`endif

  assign cap_k     = lowest_bit(cap_mask);
  assign emit_k    = lowest_bit(mask);
  assign next_mask = mask & ~(4'b0001 << emit_k);
  assign next_k    = lowest_bit(next_mask);

  // in_ready is held low for the whole reset window, not just until the next edge
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      map_q     <= '0;
      mask      <= 4'd0;
      cmd_valid <= 1'b0;
      cmd_src   <= 2'd0;
      cmd_dst   <= 2'd0;
      cmd_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      job_count <= 8'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            map_q <= map_in;
            if (!perm_ok) begin
              state <= ERR;
              err   <= 1'b1;
              mask  <= 4'd0;
            end else if (cap_mask == 4'd0) begin
              state     <= DONE;
              done      <= 1'b1;
              mask      <= 4'd0;
              job_count <= job_count + 8'd1;
            end else begin
              state     <= EMIT;
              mask      <= cap_mask;
              cmd_valid <= 1'b1;
              cmd_src   <= map_in[cap_k];
              cmd_dst   <= cap_k;
              cmd_last  <= single_bit(cap_mask);
            end
          end
        end
        EMIT: begin
          // payload only advances on a handshake, so it holds while stalled
          if (cmd_ready) begin
            mask <= next_mask;
            if (next_mask == 4'd0) begin
              state     <= DONE;
              done      <= 1'b1;
              cmd_valid <= 1'b0;
              cmd_src   <= 2'd0;
              cmd_dst   <= 2'd0;
              cmd_last  <= 1'b0;
              job_count <= job_count + 8'd1;
            end else begin
              cmd_src  <= map_q[next_k];
              cmd_dst  <= next_k;
              cmd_last <= single_bit(next_mask);
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_route_sequencer.sv
// tb/tb_route_sequencer.sv - table-driven bench for route_sequencer plus backpressure, reset and wrap sequences
module tb_route_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] map0, map1, map2, map3;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_src, cmd_dst;
  logic       cmd_last;
  logic       busy, done, err;
  logic [7:0] job_count;

  route_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .map0(map0), .map1(map1), .map2(map2), .map3(map3),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_last(cmd_last), .busy(busy), .done(done),
    .err(err), .job_count(job_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] maps;
    logic       exp_err;
    int         exp_n;
    logic [7:0] exp_src;
    logic [7:0] exp_dst;
  } vec_t;

  vec_t vecs[7];
  int   passed = 0;
  int   total  = 0;
  logic [7:0] exp_jobs;

  int         r_n, r_end, r_viol;
  logic [7:0] r_src, r_dst;
  logic [3:0] r_last;
  logic       r_err, r_done, r_rdy_end, r_rdy_after;

  function automatic logic [7:0] pk(input logic [1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic run_job(input logic [7:0] maps, input logic [31:0] rdy);
    int         waited;
    logic       pv, pr;
    logic [4:0] pc;
    r_n = 0; r_src = '0; r_dst = '0; r_last = '0; r_err = 0; r_done = 0;
    r_end = 0; r_viol = 0; r_rdy_end = 1'b1; r_rdy_after = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    {map3, map2, map1, map0} = maps;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pv = 1'b0; pr = 1'b0; pc = '0;
    for (int i = 1; i <= 20; i++) begin
      cmd_ready = rdy[i-1];
      #1;
      if (pv && !pr && !(cmd_valid && {cmd_src, cmd_dst, cmd_last} == pc)) r_viol++;
      if ((done && err) || ((done || err) && cmd_valid)) r_viol++;
      if (cmd_valid && cmd_ready && r_n < 4) begin
        r_src[2*r_n +: 2] = cmd_src;
        r_dst[2*r_n +: 2] = cmd_dst;
        r_last[r_n]       = cmd_last;
        r_n++;
      end
      pv = cmd_valid; pr = cmd_ready; pc = {cmd_src, cmd_dst, cmd_last};
      if (done || err) begin
        r_done = done; r_err = err; r_end = i; r_rdy_end = in_ready;
        break;
      end
      @(negedge clk);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    #1;
    r_rdy_after = in_ready;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; cmd_ready = 1'b1;
    map0 = 2'd0; map1 = 2'd0; map2 = 2'd0; map3 = 2'd0;
    exp_jobs = 8'd0;

    vecs[0] = '{pk(3,2,1,0), 1'b0, 4, pk(3,2,1,0), pk(0,1,2,3)};
    vecs[1] = '{pk(1,2,3,0), 1'b0, 4, pk(1,2,3,0), pk(0,1,2,3)};
    vecs[2] = '{pk(2,0,3,1), 1'b0, 4, pk(2,0,3,1), pk(0,1,2,3)};
    vecs[3] = '{pk(0,0,1,2), 1'b1, 0, 8'h00,       8'h00};
    vecs[4] = '{pk(3,3,3,3), 1'b1, 0, 8'h00,       8'h00};
`ifdef SKIP_IDENTITY_EN
    vecs[5] = '{pk(0,1,2,3), 1'b0, 0, 8'h00,       8'h00};
    vecs[6] = '{pk(0,2,1,3), 1'b0, 2, pk(2,1,0,0), pk(1,2,0,0)};
`else
    vecs[5] = '{pk(0,1,2,3), 1'b0, 4, pk(0,1,2,3), pk(0,1,2,3)};
    vecs[6] = '{pk(0,2,1,3), 1'b0, 4, pk(0,2,1,3), pk(0,1,2,3)};
`endif

    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_job_count", job_count, 0);
    check("rst_payload", {cmd_src, cmd_dst, cmd_last}, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_release", in_ready, 1);

    for (int v = 0; v < 7; v++) begin
      run_job(vecs[v].maps, 32'hFFFF_FFFF);
      if (!vecs[v].exp_err) exp_jobs = exp_jobs + 8'd1;
      check($sformatf("v%0d_err", v), r_err, vecs[v].exp_err);
      check($sformatf("v%0d_done", v), r_done, !vecs[v].exp_err);
      check($sformatf("v%0d_end_cycle", v), r_end, vecs[v].exp_err ? 1 : vecs[v].exp_n + 1);
      check($sformatf("v%0d_ncmd", v), r_n, vecs[v].exp_n);
      check($sformatf("v%0d_src", v), r_src, vecs[v].exp_src);
      check($sformatf("v%0d_dst", v), r_dst, vecs[v].exp_dst);
      check($sformatf("v%0d_last", v), r_last, vecs[v].exp_n == 0 ? 0 : (1 << (vecs[v].exp_n - 1)));
      check($sformatf("v%0d_in_ready_end", v), r_rdy_end, 0);
      check($sformatf("v%0d_in_ready_after", v), r_rdy_after, 1);
      check($sformatf("v%0d_viol", v), r_viol, 0);
      check($sformatf("v%0d_job_count", v), job_count, exp_jobs);
    end

    // second command stalled for three cycles
    run_job(pk(1,2,3,0), 32'hFFFF_FFF1);
    exp_jobs = exp_jobs + 8'd1;
    check("bp_ncmd", r_n, 4);
    check("bp_src", r_src, pk(1,2,3,0));
    check("bp_dst", r_dst, pk(0,1,2,3));
    check("bp_last", r_last, 4'b1000);
    check("bp_done_cycle", r_end, 8);
    check("bp_hold_viol", r_viol, 0);
    check("bp_job_count", job_count, exp_jobs);

    // reset while the third command is on the bus
    @(negedge clk);
    {map3, map2, map1, map0} = pk(3,2,1,0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("mid_pre_valid", cmd_valid, 1);
    check("mid_pre_dst", cmd_dst, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_jobs", job_count, 0);
    check("mid_rst_done_err", {done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_jobs = 8'd0;
    run_job(pk(3,2,1,0), 32'hFFFF_FFFF);
    exp_jobs = exp_jobs + 8'd1;
    check("post_rst_ncmd", r_n, 4);
    check("post_rst_src", r_src, pk(3,2,1,0));
    check("post_rst_jobs", job_count, exp_jobs);

    // counter wrap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_jobs = 8'd0;
    for (int j = 0; j < 255; j++) begin
      run_job(pk(3,2,1,0), 32'hFFFF_FFFF);
      exp_jobs = exp_jobs + 8'd1;
    end
    check("wrap_255", job_count, exp_jobs);
    check("wrap_255_abs", job_count, 255);
    run_job(pk(0,0,1,2), 32'hFFFF_FFFF);
    check("wrap_err_pulse", r_err, 1);
    check("wrap_err_jobs", job_count, 255);
    run_job(pk(3,2,1,0), 32'hFFFF_FFFF);
    exp_jobs = exp_jobs + 8'd1;
    check("wrap_256", job_count, exp_jobs);
    check("wrap_256_abs", job_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
